l2_cache_wb: RTL and testbench
==============================

Name: l2_cache_wb

Overview:
- Parametrised write-back, write-allocate, N-way set-associative L2 cache.
- Successor to the read-only L2: adds dirty-line eviction, a memory write channel, true-LRU replacement and fully generic geometry.
- Sits between the L1 request port and main memory. Memory transfers are word-serial, one 32-bit word per mem_ready handshake.

Parameters:
- DATA_WIDTH, 32, word width in bits; bytes per word = DATA_WIDTH/8.
- ADDR_WIDTH, 11, byte address width.
- CACHE_SIZE, 512, total data capacity in bytes.
- BLOCK_SIZE, 32, line size in bytes; WORDS_PER_LINE = BLOCK_SIZE/(DATA_WIDTH/8).
- NUM_WAYS, 4, associativity (power of 2, 1..8).
- Derived: NUM_SETS = CACHE_SIZE/(BLOCK_SIZE*NUM_WAYS).
- Derived address fields: offset = log2(BLOCK_SIZE) bits, index = log2(NUM_SETS) bits, tag = remaining bits.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- l1_cache_addr  in  ADDR_WIDTH  byte address, word aligned.
- l1_cache_data_in  in  DATA_WIDTH  write data.
- l1_cache_data_out  out  DATA_WIDTH  read data, valid when l1_cache_ready=1.
- l1_cache_read  in  1  read request.
- l1_cache_write  in  1  write request.
- l1_cache_ready  out  1  one-cycle completion pulse.
- l1_cache_hit  out  1  qualifies ready: 1 = hit, 0 = serviced via miss.
- mem_addr  out  ADDR_WIDTH  word-aligned memory byte address.
- mem_data_out  out  DATA_WIDTH  writeback data.
- mem_data_in  in  DATA_WIDTH  fill data.
- mem_read  out  1  word read request.
- mem_write  out  1  word write request.
- mem_ready  in  1  memory word completion.

Behaviour:
- Reset (rst=1 at posedge):
  - All valid, dirty and LRU state cleared; FSM to IDLE.
  - All outputs 0: ready, hit, mem_read, mem_write, data_out, mem_addr, mem_data_out.
  - Reset mid-transfer aborts the transfer; no partial line is left valid.
- States: IDLE, LOOKUP, WB_REQ, WB_GAP, FILL_REQ, FILL_GAP, RESPOND.
- IDLE:
  - A request is sampled when read or write is high at posedge; addr and data are latched.
  - read and write both high: treated as a write, read ignored.
  - Requests arriving in any non-IDLE state are ignored and not queued.
- LOOKUP (1 cycle): tag compare across all ways of the set.
  - Read hit: next cycle ready=1, hit=1, data_out=word. Latency = 2 cycles from sampling the request.
  - Write hit: word updated, dirty set; ready=1, hit=1 with the same latency.
  - Every hit makes the accessed way MRU.
  - Miss, victim selection: lowest-index invalid way; if none, the LRU way.
  - Miss with dirty victim goes to WB_REQ; otherwise goes to FILL_REQ.
- WB_REQ:
  - mem_write=1, mem_addr = {victim tag, index, word k, 00}, mem_data_out = victim word k.
  - All held stable until mem_ready=1 is sampled. Words are sent k = 0..WORDS_PER_LINE-1.
- WB_GAP: one cycle with mem_write=0; mem_ready is ignored. Then the next word, or FILL_REQ after the last word.
- FILL_REQ:
  - mem_read=1, mem_addr = {req tag, index, word k, 00}, held until mem_ready=1 is sampled.
  - mem_data_in is captured on that edge.
- FILL_GAP: one cycle with mem_read=0; mem_ready is ignored. After the last word the line is made valid with the new tag and becomes MRU.
- Line state after fill:
  - Write miss: the latched word is merged over the fill data and the line is marked dirty.
  - Read miss: the line is clean.
- RESPOND: ready=1, hit=0, data_out = requested word (post-merge for writes); then IDLE.
- mem_read and mem_write are never high in the same cycle.
- Word counter wraps from WORDS_PER_LINE-1 to 0 at each phase end.
- LRU: per-set age counters of log2(NUM_WAYS) bits.
  - On access, ways younger than the accessed way age by 1; the accessed way is set to 0.
  - The way with age NUM_WAYS-1 is LRU.
- ready and hit are single-cycle pulses. data_out holds its value until the next completion.

Optional Feature:
- Macro: L2_PERF_COUNTERS_EN.
- When defined, adds outputs perf_hits, perf_misses and perf_writebacks (32 bits each).
  - perf_hits increments on hit completion; perf_misses on miss completion; perf_writebacks once per dirty line evicted.
  - All three clear on rst and saturate at all-ones.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Memory model: word i = i*4+0x1000; one-cycle registered mem_ready.
- Cold read addr 20:
  - Required: 8 mem_read words at addrs 0,4,...,28 with no mem_write.
  - Then ready=1, hit=0, data_out=0x1014.
- Re-read addr 20: ready=1, hit=1 two cycles after the request, data 0x1014, mem_read stays 0.
- Write 0xDEADBEEF to addr 24 (hit), then read 24: hit=1, data 0xDEADBEEF, no memory traffic.
- Eviction with defaults (4 sets, 128 B set stride):
  - Read 128, 256, 384 (fills the remaining ways of set 0), then read 512.
  - Required: 8 mem_write words to addrs 0..28, with word 6 = 0xDEADBEEF and others matching memory.
  - Then 8 fills from 512..540; data_out=0x1200.
- LRU: with set 0 holding 128, 256, 384, 512, touch 128 then read 640.
  - Required: victim is line 256 (clean), so no mem_write occurs.
  - Later read 128 still hits.
- Reset asserted during the 4th fill word: mem_read=0 next cycle; a subsequent read of that address misses and refills.

Source files
------------

// File: rtl/l2_cache_wb_if.sv
// L1 request port and word-serial memory port of the write-back L2 cache.
// slave = cache side, master = L1/memory environment side.
// Carries no state; timing is defined entirely by l2_cache_wb.
interface l2_cache_wb_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 11
);
   logic [ADDR_WIDTH-1:0] l1_cache_addr;
   logic [DATA_WIDTH-1:0] l1_cache_data_in;
   logic [DATA_WIDTH-1:0] l1_cache_data_out;
   logic                  l1_cache_read;
   logic                  l1_cache_write;
   logic                  l1_cache_ready;
   logic                  l1_cache_hit;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_data_out;
   logic [DATA_WIDTH-1:0] mem_data_in;
   logic                  mem_read;
   logic                  mem_write;
   logic                  mem_ready;

   modport slave (
      input  l1_cache_addr, l1_cache_data_in, l1_cache_read, l1_cache_write,
      input  mem_data_in, mem_ready,
      output l1_cache_data_out, l1_cache_ready, l1_cache_hit,
      output mem_addr, mem_data_out, mem_read, mem_write
   );

   modport master (
      output l1_cache_addr, l1_cache_data_in, l1_cache_read, l1_cache_write,
      output mem_data_in, mem_ready,
      input  l1_cache_data_out, l1_cache_ready, l1_cache_hit,
      input  mem_addr, mem_data_out, mem_read, mem_write
   );
endinterface

// File: rtl/l2_cache_wb.sv
// Write-back, write-allocate, N-way set-associative L2 with true-LRU ages; optional perf counters (L2_PERF_COUNTERS_EN).
// Latency: hit completes 2 cycles after the request is sampled; a miss adds word-serial writeback and fill phases.
// Backpressure: requests arriving outside IDLE are dropped; memory words stall until mem_ready is sampled.
module l2_cache_wb #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 11,
   parameter int CACHE_SIZE = 512,
   parameter int BLOCK_SIZE = 32,
   parameter int NUM_WAYS   = 4
) (
   input  logic         clk,
   input  logic         rst,
   l2_cache_wb_if.slave bus
`ifdef L2_PERF_COUNTERS_EN
   ,
   output logic [31:0]  perf_hits,
   output logic [31:0]  perf_misses,
   output logic [31:0]  perf_writebacks
`endif
);
   // Geometry; assumes at least 2 sets and at least 2 words per line.
   localparam int BYTES    = DATA_WIDTH / 8;
   localparam int WPL      = BLOCK_SIZE / BYTES;
   localparam int NUM_SETS = CACHE_SIZE / (BLOCK_SIZE * NUM_WAYS);
   localparam int BOFF_W   = $clog2(BYTES);
   localparam int WORD_W   = $clog2(WPL);
   localparam int OFF_W    = $clog2(BLOCK_SIZE);
   localparam int IDX_W    = $clog2(NUM_SETS);
   localparam int TAG_W    = ADDR_WIDTH - OFF_W - IDX_W;
   localparam int WAY_W    = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

   typedef enum logic [2:0] {
      IDLE, LOOKUP, WB_REQ, WB_GAP, FILL_REQ, FILL_GAP, RESPOND
   } state_t;

   state_t state, state_nxt;

   logic [DATA_WIDTH-1:0] data_arr  [NUM_SETS][NUM_WAYS][WPL];
   logic [TAG_W-1:0]      tag_arr   [NUM_SETS][NUM_WAYS];
   logic [NUM_WAYS-1:0]   valid_arr [NUM_SETS];
   logic [NUM_WAYS-1:0]   dirty_arr [NUM_SETS];
   logic [WAY_W-1:0]      age_arr   [NUM_SETS][NUM_WAYS];

   logic [TAG_W-1:0]      req_tag;
   logic [IDX_W-1:0]      req_idx;
   logic [WORD_W-1:0]     req_word;
   logic                  req_wr;
   logic [DATA_WIDTH-1:0] req_dat;
   logic [WORD_W-1:0]     cnt;
   logic [WAY_W-1:0]      vict_way;
   logic                  hit_q;
   logic [DATA_WIDTH-1:0] data_out_q;

   logic                  lk_hit, inv_found;
   logic [WAY_W-1:0]      hit_way, inv_way, lru_way, vict_sel, touch_way;
   logic [WAY_W-1:0]      eff_age;
   logic [WAY_W-1:0]      age_touched [NUM_WAYS];
   logic                  cnt_last;

   assign cnt_last = (cnt == WORD_W'(WPL - 1));

   // Tag compare and victim choice for the latched set; descending scan so the lowest way wins.
   always_comb begin
      lk_hit    = 1'b0;
      hit_way   = '0;
      inv_found = 1'b0;
      inv_way   = '0;
      lru_way   = '0;
      for (int w = NUM_WAYS - 1; w >= 0; w--) begin
         if (valid_arr[req_idx][w] && (tag_arr[req_idx][w] == req_tag)) begin
            lk_hit  = 1'b1;
            hit_way = WAY_W'(w);
         end
         if (!valid_arr[req_idx][w]) begin
            inv_found = 1'b1;
            inv_way   = WAY_W'(w);
         end
         if (age_arr[req_idx][w] == WAY_W'(NUM_WAYS - 1)) begin
            lru_way = WAY_W'(w);
         end
      end
      vict_sel = inv_found ? inv_way : lru_way;
   end

   // New ages when a way becomes MRU; an invalid way counts as oldest so valid ages stay a permutation.
   always_comb begin
      touch_way = (state == LOOKUP) ? hit_way : vict_way;
      eff_age   = valid_arr[req_idx][touch_way] ? age_arr[req_idx][touch_way] : WAY_W'(NUM_WAYS - 1);
      for (int w = 0; w < NUM_WAYS; w++) begin
         if (WAY_W'(w) == touch_way) begin
            age_touched[w] = '0;
         end else if (valid_arr[req_idx][w] && (age_arr[req_idx][w] < eff_age)) begin
            age_touched[w] = age_arr[req_idx][w] + WAY_W'(1);
         end else begin
            age_touched[w] = age_arr[req_idx][w];
         end
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     if (bus.l1_cache_read || bus.l1_cache_write) state_nxt = LOOKUP;
         LOOKUP: begin
            if (lk_hit)                                                state_nxt = RESPOND;
            else if (valid_arr[req_idx][vict_sel] && dirty_arr[req_idx][vict_sel]) state_nxt = WB_REQ;
            else                                                       state_nxt = FILL_REQ;
         end
         WB_REQ:   if (bus.mem_ready) state_nxt = WB_GAP;
         WB_GAP:   state_nxt = (cnt == '0) ? FILL_REQ : WB_REQ;
         FILL_REQ: if (bus.mem_ready) state_nxt = FILL_GAP;
         FILL_GAP: state_nxt = (cnt == '0) ? RESPOND : FILL_REQ;
         RESPOND:  state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   // Outputs decoded from the current state; idle values are all zero.
   always_comb begin
      bus.mem_read          = 1'b0;
      bus.mem_write         = 1'b0;
      bus.mem_addr          = '0;
      bus.mem_data_out      = '0;
      bus.l1_cache_ready    = 1'b0;
      bus.l1_cache_hit      = 1'b0;
      bus.l1_cache_data_out = data_out_q;
      case (state)
         WB_REQ: begin
            bus.mem_write    = 1'b1;
            bus.mem_addr     = {tag_arr[req_idx][vict_way], req_idx, cnt, {BOFF_W{1'b0}}};
            bus.mem_data_out = data_arr[req_idx][vict_way][cnt];
         end
         FILL_REQ: begin
            bus.mem_read = 1'b1;
            bus.mem_addr = {req_tag, req_idx, cnt, {BOFF_W{1'b0}}};
         end
         RESPOND: begin
            bus.l1_cache_ready = 1'b1;
            bus.l1_cache_hit   = hit_q;
         end
         default: ;
      endcase
   end

   // Request latch, word counter, line arrays and LRU ages.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < NUM_SETS; s++) begin
            valid_arr[s] <= '0;
            dirty_arr[s] <= '0;
            for (int w = 0; w < NUM_WAYS; w++) age_arr[s][w] <= '0;
         end
         req_tag    <= '0;
         req_idx    <= '0;
         req_word   <= '0;
         req_wr     <= 1'b0;
         req_dat    <= '0;
         cnt        <= '0;
         vict_way   <= '0;
         hit_q      <= 1'b0;
         data_out_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.l1_cache_read || bus.l1_cache_write) begin
                  req_tag  <= bus.l1_cache_addr[ADDR_WIDTH-1 -: TAG_W];
                  req_idx  <= bus.l1_cache_addr[OFF_W +: IDX_W];
                  req_word <= bus.l1_cache_addr[BOFF_W +: WORD_W];
                  req_wr   <= bus.l1_cache_write;
                  req_dat  <= bus.l1_cache_data_in;
               end
            end
            LOOKUP: begin
               hit_q    <= lk_hit;
               vict_way <= vict_sel;
               cnt      <= '0;
               if (lk_hit) begin
                  for (int w = 0; w < NUM_WAYS; w++) age_arr[req_idx][w] <= age_touched[w];
                  if (req_wr) begin
                     data_arr[req_idx][hit_way][req_word] <= req_dat;
                     dirty_arr[req_idx][hit_way]          <= 1'b1;
                     data_out_q                           <= req_dat;
                  end else begin
                     data_out_q <= data_arr[req_idx][hit_way][req_word];
                  end
               end
            end
            WB_REQ: begin
               if (bus.mem_ready) cnt <= cnt_last ? '0 : cnt + WORD_W'(1);
            end
            FILL_REQ: begin
               if (bus.mem_ready) begin
                  data_arr[req_idx][vict_way][cnt] <= bus.mem_data_in;
                  cnt <= cnt_last ? '0 : cnt + WORD_W'(1);
               end
            end
            FILL_GAP: begin
               if (cnt == '0) begin
                  valid_arr[req_idx][vict_way] <= 1'b1;
                  dirty_arr[req_idx][vict_way] <= req_wr;
                  tag_arr[req_idx][vict_way]   <= req_tag;
                  for (int w = 0; w < NUM_WAYS; w++) age_arr[req_idx][w] <= age_touched[w];
                  if (req_wr) begin
                     data_arr[req_idx][vict_way][req_word] <= req_dat;
                     data_out_q                            <= req_dat;
                  end else begin
                     data_out_q <= data_arr[req_idx][vict_way][req_word];
                  end
               end
            end
            default: ;
         endcase
      end
   end

`ifdef L2_PERF_COUNTERS_EN
   // Saturating event counters: completions by kind, and dirty-line evictions.
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_hits       <= '0;
         perf_misses     <= '0;
         perf_writebacks <= '0;
      end else begin
         if (state == RESPOND && hit_q && perf_hits != '1)    perf_hits   <= perf_hits + 32'd1;
         if (state == RESPOND && !hit_q && perf_misses != '1) perf_misses <= perf_misses + 32'd1;
         if (state == LOOKUP && state_nxt == WB_REQ && perf_writebacks != '1)
            perf_writebacks <= perf_writebacks + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_l2_cache_wb.sv
// Bench for l2_cache_wb: directed scenarios plus random traffic against a recency-list cache model.
// Memory responder raises mem_ready one cycle after a request and logs every completed word.
// All comparisons go through chk; one summary line at the end.
module tb_l2_cache_wb;
   localparam int NW = 4;
   localparam int NS = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   l2_cache_wb_if #(.DATA_WIDTH(32), .ADDR_WIDTH(11)) bus ();

`ifdef L2_PERF_COUNTERS_EN
   logic [31:0] perf_hits, perf_misses, perf_writebacks;
   l2_cache_wb dut (.clk(clk), .rst(rst), .bus(bus.slave),
                    .perf_hits(perf_hits), .perf_misses(perf_misses),
                    .perf_writebacks(perf_writebacks));
`else
   l2_cache_wb dut (.clk(clk), .rst(rst), .bus(bus.slave));
`endif

   typedef struct packed {
      logic        wr;
      logic [10:0] addr;
      logic [31:0] dat;
   } xfer_t;

   typedef struct packed {
      logic [5:0]   line;
      logic         dirty;
      logic [255:0] dat;
   } line_t;

   int          n_chk = 0;
   int          n_err = 0;
   int          overlap = 0;
   logic [31:0] mem_arr [512];
   logic [31:0] ref_mem [512];
   xfer_t       act_q [$];
   xfer_t       exp_q [$];
   line_t       cq [$];
   bit          pend = 1'b0;
   bit          last_hit;
   logic [31:0] last_dat;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Memory responder: ready one cycle after the request is seen, cleared after the handshake.
   always @(negedge clk) begin
      xfer_t x;
      if (bus.mem_read && bus.mem_write) overlap++;
      if (rst) begin
         bus.mem_ready = 1'b0;
         pend = 1'b0;
      end else if (bus.mem_ready) begin
         bus.mem_ready = 1'b0;
      end else if (bus.mem_read || bus.mem_write) begin
         if (pend) begin
            pend   = 1'b0;
            x.wr   = bus.mem_write;
            x.addr = bus.mem_addr;
            if (bus.mem_write) begin
               mem_arr[bus.mem_addr[10:2]] = bus.mem_data_out;
               x.dat = bus.mem_data_out;
            end else begin
               bus.mem_data_in = mem_arr[bus.mem_addr[10:2]];
               x.dat = bus.mem_data_in;
            end
            act_q.push_back(x);
            bus.mem_ready = 1'b1;
         end else begin
            pend = 1'b1;
         end
      end else begin
         pend = 1'b0;
      end
   end

   // Reference: lines of all sets in one queue, most recently used first.
   task automatic model_access(input bit wr, input int addr, input logic [31:0] wdat,
                               output bit hit, output logic [31:0] rdat);
      int    line  = addr / 32;
      int    set   = line % NS;
      int    w     = (addr / 4) % 8;
      int    found = -1;
      int    cnt   = 0;
      int    last  = -1;
      line_t e, v;
      xfer_t x;
      exp_q.delete();
      foreach (cq[i]) begin
         if (int'(cq[i].line) == line) found = i;
         if (int'(cq[i].line) % NS == set) begin
            cnt++;
            last = i;
         end
      end
      if (found >= 0) begin
         hit = 1'b1;
         e = cq[found];
         cq.delete(found);
      end else begin
         hit = 1'b0;
         if (cnt == NW) begin
            v = cq[last];
            cq.delete(last);
            if (v.dirty) begin
               for (int k = 0; k < 8; k++) begin
                  x.wr   = 1'b1;
                  x.addr = 11'(int'(v.line) * 32 + k * 4);
                  x.dat  = v.dat[k*32 +: 32];
                  exp_q.push_back(x);
                  ref_mem[int'(v.line) * 8 + k] = x.dat;
               end
            end
         end
         e.line  = 6'(line);
         e.dirty = 1'b0;
         for (int k = 0; k < 8; k++) begin
            e.dat[k*32 +: 32] = ref_mem[line * 8 + k];
            x.wr   = 1'b0;
            x.addr = 11'(line * 32 + k * 4);
            x.dat  = ref_mem[line * 8 + k];
            exp_q.push_back(x);
         end
      end
      if (wr) begin
         e.dat[w*32 +: 32] = wdat;
         e.dirty = 1'b1;
      end
      rdat = e.dat[w*32 +: 32];
      cq.push_front(e);
   endtask

   // One L1 request, compared against the model: response, latency, memory traffic, pulse width.
   task automatic run_req(input bit rd, input bit wr, input int addr, input logic [31:0] wdat);
      bit          exp_hit;
      logic [31:0] exp_dat;
      int          cyc;
      int          n;
      model_access(wr, addr, wdat, exp_hit, exp_dat);
      act_q.delete();
      @(negedge clk);
      bus.l1_cache_addr    = 11'(addr);
      bus.l1_cache_data_in = wdat;
      bus.l1_cache_read    = rd;
      bus.l1_cache_write   = wr;
      @(negedge clk);
      bus.l1_cache_read  = 1'b0;
      bus.l1_cache_write = 1'b0;
      cyc = 1;
      while (!bus.l1_cache_ready && cyc < 2000) begin
         @(negedge clk);
         cyc++;
      end
      chk("ready_seen", bus.l1_cache_ready, 1'b1);
      chk("hit", bus.l1_cache_hit, exp_hit);
      chk("data_out", bus.l1_cache_data_out, exp_dat);
      if (exp_hit) chk("hit_latency", cyc, 2);
      chk("mem_words", act_q.size(), exp_q.size());
      n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) chk("mem_xfer", act_q[i], exp_q[i]);
      last_hit = bus.l1_cache_hit;
      last_dat = bus.l1_cache_data_out;
      @(negedge clk);
      chk("ready_pulse", bus.l1_cache_ready, 1'b0);
      chk("data_hold", bus.l1_cache_data_out, exp_dat);
   endtask

   function automatic int count_writes();
      int c = 0;
      foreach (act_q[i]) if (act_q[i].wr) c++;
      return c;
   endfunction

   initial begin
      xfer_t x;
      int    cyc;
      for (int i = 0; i < 512; i++) begin
         mem_arr[i] = 32'(i * 4 + 32'h1000);
         ref_mem[i] = mem_arr[i];
      end
      rst = 1'b1;
      bus.l1_cache_addr    = '0;
      bus.l1_cache_data_in = '0;
      bus.l1_cache_read    = 1'b0;
      bus.l1_cache_write   = 1'b0;
      bus.mem_data_in      = '0;
      bus.mem_ready        = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_ready", bus.l1_cache_ready, 1'b0);
      chk("rst_hit", bus.l1_cache_hit, 1'b0);
      chk("rst_mem_read", bus.mem_read, 1'b0);
      chk("rst_mem_write", bus.mem_write, 1'b0);
      chk("rst_data_out", bus.l1_cache_data_out, 32'h0);
      chk("rst_mem_addr", bus.mem_addr, 11'h0);
      chk("rst_mem_data_out", bus.mem_data_out, 32'h0);
      rst = 1'b0;

      // Cold read, re-read hit, write hit and read-back.
      run_req(1, 0, 20, 32'h0);
      chk("cold_data", last_dat, 32'h1014);
      chk("cold_no_write", count_writes(), 0);
      run_req(1, 0, 20, 32'h0);
      chk("reread_hit", last_hit, 1'b1);
      run_req(0, 1, 24, 32'hDEADBEEF);
      run_req(1, 0, 24, 32'h0);
      chk("wr_readback", last_dat, 32'hDEADBEEF);

      // Fill the rest of set 0, then evict the dirty line at 0.
      run_req(1, 0, 128, 32'h0);
      run_req(1, 0, 256, 32'h0);
      run_req(1, 0, 384, 32'h0);
      run_req(1, 0, 512, 32'h0);
      chk("evict_writes", count_writes(), 8);
      if (act_q.size() > 6) begin
         x = act_q[6];
         chk("evict_word6", x.dat, 32'hDEADBEEF);
      end
      chk("evict_data", last_dat, 32'h1200);

      // LRU: touching 128 leaves the clean line 256 as victim.
      run_req(1, 0, 128, 32'h0);
      run_req(1, 0, 640, 32'h0);
      chk("lru_no_write", count_writes(), 0);
      run_req(1, 0, 128, 32'h0);
      chk("lru_keep_128", last_hit, 1'b1);

      // Random traffic over a small line pool to mix hits, misses and dirty evictions.
      for (int t = 0; t < 200; t++) begin
         int  line = $urandom_range(0, 19);
         int  word = $urandom_range(0, 7);
         int  kind = $urandom_range(0, 3);
         bit  wr   = (kind >= 2);
         bit  rd   = (kind != 2);
         run_req(rd, wr, line * 32 + word * 4, $urandom);
      end

      // Reset during the 4th fill word of a cold read.
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      cq.delete();
      act_q.delete();
      bus.l1_cache_addr  = 11'h300;
      bus.l1_cache_read  = 1'b1;
      @(negedge clk);
      bus.l1_cache_read  = 1'b0;
      cyc = 0;
      while (!(act_q.size() == 3 && bus.mem_read) && cyc < 500) begin
         @(negedge clk);
         cyc++;
      end
      chk("abort_reached", (act_q.size() == 3 && bus.mem_read), 1'b1);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_mem_read", bus.mem_read, 1'b0);
      chk("abort_ready", bus.l1_cache_ready, 1'b0);
      chk("abort_data_out", bus.l1_cache_data_out, 32'h0);
      rst = 1'b0;
      run_req(1, 0, 32'h300, 32'h0);
      chk("refill_miss", last_hit, 1'b0);
      chk("refill_data", last_dat, 32'h1300);

      chk("rw_overlap", overlap, 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
